serial_priority_encoder_eight_to_three: RTL and testbench
=========================================================

// Module: serial_priority_encoder_eight_to_three
// PURPOSE
//  Inverse of the 3-to-8 decoder: accepts an 8-bit request vector and emits the index of each set
//  bit as a 3-bit code, one per output handshake, in priority order.
//  Index i corresponds to decoder output bit i (bit 0 = code 3'd0).
//  Sits between request/interrupt sources and index-consuming logic.
//  Supports round-trip: decoder(out_index) == the one-hot bit consumed.
// PARAMETERS
//  LSB_FIRST  1  1: lowest set bit has priority; 0: highest set bit has priority
// PORTS
//  clk        in   1  sole clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  in_data valid
//  in_ready   out  1  block can accept a vector
//  in_data    in   8  request vector
//  out_valid  out  1  out_index/out_last/out_err valid
//  out_ready  in   1  consumer accepts the beat
//  out_index  out  3  encoded index of the current priority bit
//  out_last   out  1  final beat of the current vector
//  out_err    out  1  vector was all-zero (no valid index)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset:
//   - state=IDLE; pending=8'h00; err_flag=0; out_valid=0; out_index=0; out_last=0; out_err=0.
//   - in_ready=0 while rst is high; in_ready=1 on the first clock edge after rst is deasserted.
//  States:
//   - IDLE: in_ready=1, out_valid=0.
//   - DRAIN: out_valid=1.
//  Accept rule:
//   - Accept on (in_valid & in_ready); pending<=in_data; go to DRAIN.
//   - If in_data==0: err_flag<=1 (one beat with out_err=1, out_index=0, out_last=1).
//  out_index:
//   - Computed from the registered pending vector only (no comb path from in_data).
//   - LSB_FIRST=1: lowest set bit; LSB_FIRST=0: highest set bit.
//  out_last = (pending has exactly one bit set) | err_flag.
//  Beat consumed on (out_valid & out_ready): clear the bit at out_index in pending.
//   - If out_last: go to IDLE and clear err_flag.
//  Latency: first beat out_valid one cycle after the input handshake.
//  in_ready = IDLE | (out_valid & out_ready & out_last).
//   - Gives back-to-back vectors with no bubble.
//   - On that simultaneous edge the new vector loads and the state stays DRAIN.
//  Stall: while out_valid & ~out_ready, out_index/out_last/out_err hold stable.
//  in_data changes while in DRAIN are ignored (no input handshake).
//  Bit count: a vector with k set bits yields exactly k beats; the all-zero vector yields 1 beat.
//  Reset mid-DRAIN: pending discarded; out_valid deasserts asynchronously; no partial beats after.
// STRUCTURE
//  Package serial_encoder_pkg:
//   - localparam VEC_W=8, IDX_W=3.
//   - typedef enum logic {IDLE, DRAIN} enc_state_t.
//  Sub-module priority_pick8 (combinational):
//   - inputs vec[7:0], lsb_first; outputs idx[2:0], onehot[7:0], single.
//   - Reused for the clear mask and out_last.
//  Top: state register, pending register, err_flag register, handshake logic.
// TESTING
//  1. in_data=8'b0000_0100 -> one beat: idx=2, last=1, err=0; then in_ready=1.
//  2. in_data=8'b1001_0010, LSB_FIRST=1 -> idx 1,4,7; last only on 7.
//     LSB_FIRST=0 -> idx 7,4,1.
//  3. Vector 8'h81, out_ready low 3 cycles -> idx=0 held stable; then idx 0, then 7 (last).
//  4. in_data=8'h00 -> one beat: err=1, idx=0, last=1.
//  5. Back-to-back 8'h01 then 8'h40 with out_ready=1 -> idx 0 then 6 on consecutive cycles.
//  6. rst during DRAIN of 8'hFF after 2 beats -> out_valid=0 immediately.
//     After release: in_ready=1, no stale beats.
//  7. Round-trip: for code 0..7, decoder(code) -> block -> single beat idx==code, last=1.

Source files
------------

// File: rtl/serial_encoder_pkg.sv
// rtl/serial_encoder_pkg.sv - shared widths and state type for the serial priority encoder
package serial_encoder_pkg;
  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, DRAIN} enc_state_t;
endpackage

// File: rtl/priority_pick8.sv
// rtl/priority_pick8.sv - combinational pick of the priority set bit in an 8-bit vector
module priority_pick8
  import serial_encoder_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             lsb_first,
  output logic [IDX_W-1:0] idx,
  output logic [VEC_W-1:0] onehot,
  output logic             single
);

  always_comb begin
    idx = '0;
    // Scan away from the priority end so the last hit is the winner.
    if (lsb_first) begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < VEC_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
    onehot = vec & (VEC_W'(1) << idx);
    single = (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);
  end

endmodule

// File: rtl/serial_priority_encoder_eight_to_three.sv
// rtl/serial_priority_encoder_eight_to_three.sv - drains a request vector as one index per output beat
module serial_priority_encoder_eight_to_three
  import serial_encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_err
);

  enc_state_t       state;
  logic [VEC_W-1:0] pending;
  logic [VEC_W-1:0] clear_mask;
  logic             err_flag;
  logic             ready_en;
  logic             single;

  priority_pick8 u_pick (
    .vec       (pending),
    .lsb_first (LSB_FIRST),
    .idx       (out_index),
    .onehot    (clear_mask),
    .single    (single)
  );

  assign out_valid = (state == DRAIN);
  assign out_last  = single | err_flag;
  assign out_err   = err_flag;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_en & ((state == IDLE) | (out_valid & out_ready & out_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      err_flag <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (in_valid && in_ready) begin
        pending  <= in_data;
        err_flag <= (in_data == '0);
        state    <= DRAIN;
      end else if (out_valid && out_ready) begin
        pending <= pending & ~clear_mask;
        if (out_last) begin
          state    <= IDLE;
          err_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_priority_encoder_eight_to_three.sv
// tb/tb_serial_priority_encoder_eight_to_three.sv - model-checked bench for both priority orders
module tb_serial_priority_encoder_eight_to_three;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       err;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready_l, out_valid_l, out_last_l, out_err_l;
  logic [2:0] out_index_l;
  logic       in_ready_m, out_valid_m, out_last_m, out_err_m;
  logic [2:0] out_index_m;

  int checks = 0;
  int failures = 0;

  beat_t q_lsb[$];
  beat_t q_msb[$];
  beat_t log_lsb[$];
  beat_t log_msb[$];
  logic  ready_en = 1'b0;

  always #5 clk = ~clk;

  serial_priority_encoder_eight_to_three #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_index(out_index_l),
    .out_last(out_last_l), .out_err(out_err_l)
  );

  serial_priority_encoder_eight_to_three #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_index(out_index_m),
    .out_last(out_last_m), .out_err(out_err_m)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    if (!ready_en) return 1'b0;
    if (q_lsb.size() == 0) return 1'b1;
    return out_ready && q_lsb[0].last;
  endfunction

  // Expected beat lists come straight from the set bits of the vector.
  task automatic push_vec(input logic [7:0] v);
    int n;
    int k;
    n = $countones(v);
    if (v == 8'h00) begin
      q_lsb.push_back('{3'd0, 1'b1, 1'b1});
      q_msb.push_back('{3'd0, 1'b1, 1'b1});
    end else begin
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          k++;
          q_lsb.push_back('{3'(i), (k == n), 1'b0});
        end
      end
      k = 0;
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin
          k++;
          q_msb.push_back('{3'(i), (k == n), 1'b0});
        end
      end
    end
  endtask

  task automatic compare();
    logic mv;
    mv = (q_lsb.size() != 0);
    check("in_ready_lsb", {7'd0, in_ready_l}, {7'd0, model_ready()});
    check("in_ready_msb", {7'd0, in_ready_m}, {7'd0, model_ready()});
    check("out_valid_lsb", {7'd0, out_valid_l}, {7'd0, mv});
    check("out_valid_msb", {7'd0, out_valid_m}, {7'd0, mv});
    if (mv) begin
      check("beat_lsb", {3'd0, out_index_l, out_last_l, out_err_l}, {3'd0, q_lsb[0]});
      check("beat_msb", {3'd0, out_index_m, out_last_m, out_err_m}, {3'd0, q_msb[0]});
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] id, input logic ordy);
    logic mv;
    logic mrdy;
    @(negedge clk);
    compare();
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    if (out_valid_l && ordy) log_lsb.push_back('{out_index_l, out_last_l, out_err_l});
    if (out_valid_m && ordy) log_msb.push_back('{out_index_m, out_last_m, out_err_m});
    mv   = (q_lsb.size() != 0);
    mrdy = model_ready();
    if (mv && ordy) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
    if (iv && mrdy) push_vec(id);
    ready_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic clear_logs();
    log_lsb.delete();
    log_msb.delete();
  endtask

  // Beats packed as {b0,b1,b2}, five bits each, b0 in the top slot.
  task automatic expect_log(input string nm, input int n, input logic [14:0] e_lsb,
                            input logic [14:0] e_msb);
    check({nm, "_count_lsb"}, 8'(log_lsb.size()), 8'(n));
    check({nm, "_count_msb"}, 8'(log_msb.size()), 8'(n));
    if (log_lsb.size() == n && log_msb.size() == n) begin
      for (int i = 0; i < n; i++) begin
        check({nm, "_lsb"}, {3'd0, log_lsb[i]}, {3'd0, e_lsb[14-5*i -: 5]});
        check({nm, "_msb"}, {3'd0, log_msb[i]}, {3'd0, e_msb[14-5*i -: 5]});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid_lsb", {7'd0, out_valid_l}, 8'h00);
    check("rst_out_valid_msb", {7'd0, out_valid_m}, 8'h00);
    check("rst_in_ready", {6'd0, in_ready_l, in_ready_m}, 8'h00);
    q_lsb.delete();
    q_msb.delete();
    ready_en = 1'b0;
    @(negedge clk);
    check("rst_hold_in_ready", {6'd0, in_ready_l, in_ready_m}, 8'h00);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ready_en  = 1'b1;
  endtask

  logic [7:0] rv;

  initial begin
    #3;
    check("init_in_ready", {6'd0, in_ready_l, in_ready_m}, 8'h00);
    check("init_out_valid", {6'd0, out_valid_l, out_valid_m}, 8'h00);
    check("init_outs_lsb", {3'd0, out_index_l, out_last_l, out_err_l}, 8'h00);
    check("init_outs_msb", {3'd0, out_index_m, out_last_m, out_err_m}, 8'h00);
    @(negedge clk);
    rst      = 1'b0;
    ready_en = 1'b1;

    clear_logs();
    step(1'b1, 8'b0000_0100, 1'b1);
    idle(3);
    expect_log("single_bit", 1, {5'b010_1_0, 10'd0}, {5'b010_1_0, 10'd0});

    clear_logs();
    step(1'b1, 8'b1001_0010, 1'b1);
    idle(4);
    expect_log("three_bits", 3, {5'b001_0_0, 5'b100_0_0, 5'b111_1_0},
               {5'b111_0_0, 5'b100_0_0, 5'b001_1_0});

    clear_logs();
    step(1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hff, 1'b0);
      check("stall_idx_lsb", {5'd0, out_index_l}, 8'd0);
      check("stall_idx_msb", {5'd0, out_index_m}, 8'd7);
    end
    idle(3);
    expect_log("stall", 2, {5'b000_0_0, 5'b111_1_0, 5'd0}, {5'b111_0_0, 5'b000_1_0, 5'd0});

    clear_logs();
    step(1'b1, 8'h00, 1'b1);
    idle(2);
    expect_log("zero_vec", 1, {5'b000_1_1, 10'd0}, {5'b000_1_1, 10'd0});

    clear_logs();
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h40, 1'b1);
    idle(3);
    expect_log("back_to_back", 2, {5'b000_1_0, 5'b110_1_0, 5'd0},
               {5'b000_1_0, 5'b110_1_0, 5'd0});

    clear_logs();
    step(1'b1, 8'hff, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset();
    clear_logs();
    idle(4);
    check("post_reset_beats", 8'(log_lsb.size() + log_msb.size()), 8'd0);

    for (int c = 0; c < 8; c++) begin
      clear_logs();
      step(1'b1, 8'(1) << c, 1'b1);
      idle(2);
      expect_log("round_trip", 1, {3'(c), 2'b10, 10'd0}, {3'(c), 2'b10, 10'd0});
    end

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = 8'h00;
        1:       rv = 8'(1) << $urandom_range(0, 7);
        default: rv = 8'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 9) < 7));
    end
    idle(12);
    check("drained", 8'(q_lsb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
